// File: rtl/cpu_seq.sv
// Multi-cycle instruction sequencer for the RV32 core: stage FSM, pc update,
// trap entry (misaligned target, illegal instruction, bus timeout) and instret.
module cpu_seq #(
    parameter int unsigned     XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = XLEN'(32'h0000_0000),
    parameter logic [XLEN-1:0] TRAP_VECTOR  = XLEN'(32'h0000_0100),
    parameter bit              SKIP_MEM     = 1'b1,
    parameter int unsigned     MEM_TIMEOUT  = 16,
    parameter int unsigned     CNT_W        = 32
) (
    input  logic            CLK100MHZ,
    input  logic            rst,
    input  logic            fetch_ready,
    input  logic            illegal_instr,
    input  logic            exec_busy,
    input  logic            is_load,
    input  logic            is_store,
    input  logic            mem_ready,
    input  logic            taken_branch,
    input  logic [XLEN-1:0] branch_target,
    output logic [2:0]      state,
    output logic [XLEN-1:0] pc,
    output logic            wb_en,
    output logic            retire,
    output logic [CNT_W-1:0] instret,
    output logic            trap,
    output logic [XLEN-1:0] mepc,
    output logic [1:0]      mcause
);

    localparam int unsigned TMO_W    = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT + 1) : 1;
    localparam int unsigned TMO_LAST = (MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0;

    localparam logic [1:0] CAUSE_MISALIGN = 2'd0;
    localparam logic [1:0] CAUSE_ILLEGAL  = 2'd1;
    localparam logic [1:0] CAUSE_TIMEOUT  = 2'd2;

    typedef enum logic [2:0] {
        S_FETCH = 3'd0,
        S_RF    = 3'd1,
        S_EXEC  = 3'd2,
        S_MEM   = 3'd3,
        S_WB    = 3'd4,
        S_TRAP  = 3'd5
    } state_t;

    state_t           cur;
    state_t           nxt;
    logic [1:0]       cause_nxt;
    logic [1:0]       cause_q;
    logic [TMO_W-1:0] tmo_cnt;
    logic             access;
    logic             misaligned;

    assign access     = is_load | is_store;
    assign misaligned = taken_branch & (branch_target[1:0] != 2'b00);
    assign state      = cur;
    assign wb_en      = (cur == S_WB) & ~misaligned;

    // Next-state decode and trap cause selection
    always_comb begin
        nxt       = cur;
        cause_nxt = CAUSE_MISALIGN;
        case (cur)
            S_FETCH: if (fetch_ready) nxt = S_RF;
            S_RF: begin
                if (illegal_instr) begin
                    nxt       = S_TRAP;
                    cause_nxt = CAUSE_ILLEGAL;
                end else begin
                    nxt = S_EXEC;
                end
            end
            S_EXEC: begin
                if (!exec_busy) nxt = (access || !SKIP_MEM) ? S_MEM : S_WB;
            end
            S_MEM: begin
                // mem_ready is checked before the timeout so a same-cycle response wins
                if (!access || mem_ready) begin
                    nxt = S_WB;
                end else if (MEM_TIMEOUT != 0 && tmo_cnt == TMO_W'(TMO_LAST)) begin
                    nxt       = S_TRAP;
                    cause_nxt = CAUSE_TIMEOUT;
                end
            end
            S_WB: begin
                if (misaligned) begin
                    nxt       = S_TRAP;
                    cause_nxt = CAUSE_MISALIGN;
                end else begin
                    nxt = S_FETCH;
                end
            end
            S_TRAP:  nxt = S_FETCH;
            default: nxt = S_FETCH;
        endcase
    end

    // State, architectural registers and status pulses
    always_ff @(posedge CLK100MHZ) begin
        if (rst) begin
            cur     <= S_FETCH;
            pc      <= RESET_VECTOR;
            instret <= '0;
            mepc    <= '0;
            mcause  <= 2'd0;
            cause_q <= 2'd0;
            tmo_cnt <= '0;
            retire  <= 1'b0;
            trap    <= 1'b0;
        end else begin
            cur     <= nxt;
            retire  <= 1'b0;
            trap    <= (nxt == S_TRAP);
            tmo_cnt <= (cur == S_MEM && nxt == S_MEM) ? tmo_cnt + TMO_W'(1) : '0;
            if (nxt == S_TRAP) cause_q <= cause_nxt;
            if (cur == S_WB && !misaligned) begin
                pc      <= taken_branch ? branch_target : pc + XLEN'(4);
                instret <= instret + CNT_W'(1);
                retire  <= 1'b1;
            end
            if (cur == S_TRAP) begin
                mepc   <= pc;
                mcause <= cause_q;
                pc     <= TRAP_VECTOR;
            end
        end
    end

endmodule

// File: tb/tb_cpu_seq.sv
// Scoreboard bench for cpu_seq: directed instructions push expected retire/trap
// records; a negedge monitor pops and compares them as the DUT reports events.
module tb_cpu_seq;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        fetch_ready = 1'b0;
    logic        illegal_instr = 1'b0;
    logic        exec_busy = 1'b0;
    logic        is_load = 1'b0;
    logic        is_store = 1'b0;
    logic        mem_ready = 1'b0;
    logic        taken_branch = 1'b0;
    logic [31:0] branch_target = 32'h0;
    logic [2:0]  state;
    logic [31:0] pc;
    logic        wb_en;
    logic        retire;
    logic [2:0]  instret;
    logic        trap;
    logic [31:0] mepc;
    logic [1:0]  mcause;

    int checks = 0;
    int errors = 0;

    typedef struct {
        bit          is_trap;
        logic [31:0] pc;
        logic [2:0]  ir;
        logic [31:0] epc;
        logic [1:0]  cause;
        string       name;
    } exp_t;

    exp_t sb[$];

    // Narrow counter so the all-ones -> 0 wrap is reached in a short run
    cpu_seq #(
        .XLEN(32), .RESET_VECTOR(32'h0), .TRAP_VECTOR(32'h100),
        .SKIP_MEM(1'b1), .MEM_TIMEOUT(16), .CNT_W(3)
    ) dut (
        .CLK100MHZ(clk), .rst(rst), .fetch_ready(fetch_ready),
        .illegal_instr(illegal_instr), .exec_busy(exec_busy),
        .is_load(is_load), .is_store(is_store), .mem_ready(mem_ready),
        .taken_branch(taken_branch), .branch_target(branch_target),
        .state(state), .pc(pc), .wb_en(wb_en), .retire(retire),
        .instret(instret), .trap(trap), .mepc(mepc), .mcause(mcause)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic exp_ret(input string nm, input logic [31:0] npc, input logic [2:0] ir);
        exp_t e;
        e.is_trap = 1'b0; e.pc = npc; e.ir = ir; e.epc = 32'h0; e.cause = 2'd0; e.name = nm;
        sb.push_back(e);
    endtask

    task automatic exp_trp(input string nm, input logic [31:0] epc, input logic [1:0] cause,
                           input logic [2:0] ir);
        exp_t e;
        e.is_trap = 1'b1; e.pc = 32'h100; e.ir = ir; e.epc = epc; e.cause = cause; e.name = nm;
        sb.push_back(e);
    endtask

    // Monitor: retire is checked in its pulse cycle, trap one cycle later when mepc/mcause land
    bit   pend_trap = 1'b0;
    exp_t cur_e;
    always @(negedge clk) begin
        if (rst) begin
            pend_trap = 1'b0;
        end else begin
            if (pend_trap) begin
                pend_trap = 1'b0;
                if (sb.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_trap: got trap expected none");
                end else begin
                    cur_e = sb.pop_front();
                    chk({cur_e.name, "_kind"}, 64'(cur_e.is_trap), 64'(1));
                    chk({cur_e.name, "_pc"}, 64'(pc), 64'(cur_e.pc));
                    chk({cur_e.name, "_mepc"}, 64'(mepc), 64'(cur_e.epc));
                    chk({cur_e.name, "_mcause"}, 64'(mcause), 64'(cur_e.cause));
                    chk({cur_e.name, "_instret"}, 64'(instret), 64'(cur_e.ir));
                end
            end
            if (retire) begin
                if (sb.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_retire: got retire expected none");
                end else begin
                    cur_e = sb.pop_front();
                    chk({cur_e.name, "_kind"}, 64'(cur_e.is_trap), 64'(0));
                    chk({cur_e.name, "_pc"}, 64'(pc), 64'(cur_e.pc));
                    chk({cur_e.name, "_instret"}, 64'(instret), 64'(cur_e.ir));
                end
            end
            if (trap) pend_trap = 1'b1;
        end
    end

    // Runs one instruction from state 0 back to state 0; called at a negedge with state 0
    task automatic run_instr(input string nm, input int fdly, input bit ill, input int busy,
                             input bit ld, input bit st, input int mdly, input bit tk,
                             input logic [31:0] tgt, input int exp_s2, input int exp_s3,
                             input int exp_wb);
        int s2 = 0, s3 = 0, wb = 0, fc = 0, bc = 0, mc = 0;
        bit left = 1'b0, done = 1'b0;
        is_load = ld; is_store = st; taken_branch = tk; branch_target = tgt;
        for (int cyc = 0; cyc < 200 && !done; cyc++) begin
            if (state != 3'd0) left = 1'b1;
            if (left && state == 3'd0) begin
                done = 1'b1;
            end else begin
                fetch_ready   = (state == 3'd0) && (fc >= fdly);
                illegal_instr = (state == 3'd1) && ill;
                exec_busy     = (state == 3'd2) && (bc < busy);
                mem_ready     = (state == 3'd3) && (mdly >= 0) && (mc >= mdly);
                if (state == 3'd0) fc++;
                if (state == 3'd2) begin bc++; s2++; end
                if (state == 3'd3) begin mc++; s3++; end
                if (state == 3'd4 && wb_en) wb++;
                @(negedge clk);
            end
        end
        if (!done) begin
            checks++; errors++;
            $display("FAIL %s_timeout: got no return to state 0 expected return within 200 cycles", nm);
        end
        chk({nm, "_exec_cycles"}, 64'(s2), 64'(exp_s2));
        chk({nm, "_mem_cycles"}, 64'(s3), 64'(exp_s3));
        chk({nm, "_wb_en_count"}, 64'(wb), 64'(exp_wb));
        fetch_ready = 1'b0; illegal_instr = 1'b0; exec_busy = 1'b0; mem_ready = 1'b0;
        is_load = 1'b0; is_store = 1'b0; taken_branch = 1'b0;
    endtask

    initial begin
        int n;
        repeat (2) @(negedge clk);
        chk("rst_state", 64'(state), 64'(0));
        chk("rst_pc", 64'(pc), 64'(0));
        chk("rst_instret", 64'(instret), 64'(0));
        chk("rst_flags", 64'({retire, trap, wb_en}), 64'(0));
        chk("rst_mepc", 64'(mepc), 64'(0));
        rst = 1'b0;

        //        name          fdly ill busy ld st mdly tk target     s2 s3 wb
        exp_ret("addi0", 32'h4, 3'd1);
        run_instr("addi0",      0,  0,  0,  0, 0,  0,  0, 32'h0,       1, 0, 1);
        exp_ret("addi1", 32'h8, 3'd2);
        run_instr("addi1",      3,  0,  0,  0, 0,  0,  0, 32'h0,       1, 0, 1);
        exp_ret("addi2", 32'hC, 3'd3);
        run_instr("addi2",      0,  0,  0,  0, 0,  0,  0, 32'h0,       1, 0, 1);
        exp_ret("addi3", 32'h10, 3'd4);
        run_instr("addi3",      0,  0,  0,  0, 0,  0,  0, 32'h0,       1, 0, 1);
        exp_trp("ld_tmo", 32'h10, 2'd2, 3'd4);
        run_instr("ld_tmo",     0,  0,  0,  1, 0, -1,  0, 32'h0,       1, 16, 0);
        exp_ret("st_dly5", 32'h104, 3'd5);
        run_instr("st_dly5",    0,  0,  0,  0, 1,  5,  0, 32'h0,       1, 6, 1);
        exp_trp("jal_mis0", 32'h104, 2'd0, 3'd5);
        run_instr("jal_mis0",   0,  0,  0,  0, 0,  0,  1, 32'h42,      1, 0, 0);
        exp_ret("jal_ok0", 32'h20, 3'd6);
        run_instr("jal_ok0",    0,  0,  0,  0, 0,  0,  1, 32'h20,      1, 0, 1);
        exp_trp("jal_mis1", 32'h20, 2'd0, 3'd6);
        run_instr("jal_mis1",   0,  0,  0,  0, 0,  0,  1, 32'h42,      1, 0, 0);
        exp_ret("jal_ok1", 32'h40, 3'd7);
        run_instr("jal_ok1",    0,  0,  0,  0, 0,  0,  1, 32'h40,      1, 0, 1);
        exp_trp("illegal", 32'h40, 2'd1, 3'd7);
        run_instr("illegal",    0,  1,  0,  0, 0,  0,  0, 32'h0,       0, 0, 0);
        exp_ret("div_busy33", 32'h104, 3'd0);
        run_instr("div_busy33", 0,  0, 33,  0, 0,  0,  0, 32'h0,      34, 0, 1);
        exp_ret("ld_fast", 32'h108, 3'd1);
        run_instr("ld_fast",    0,  0,  0,  1, 0,  0,  0, 32'h0,       1, 1, 1);
        exp_ret("br_nt", 32'h10C, 3'd2);
        run_instr("br_nt",      0,  0,  0,  0, 0,  0,  0, 32'h43,      1, 0, 1);
        exp_ret("st_edge", 32'h110, 3'd3);
        run_instr("st_edge",    0,  0,  0,  0, 1, 15,  0, 32'h0,       1, 16, 1);

        // Reset during a mem stall: nothing retires or traps, everything returns to reset values
        is_store = 1'b1; fetch_ready = 1'b1; n = 0;
        for (int cyc = 0; cyc < 50 && n < 4; cyc++) begin
            if (state == 3'd3) n++;
            if (n < 4) @(negedge clk);
        end
        chk("mid_stall_reached", 64'(n), 64'(4));
        rst = 1'b1; fetch_ready = 1'b0;
        @(negedge clk);
        chk("midrst_state", 64'(state), 64'(0));
        chk("midrst_pc", 64'(pc), 64'(0));
        chk("midrst_instret", 64'(instret), 64'(0));
        chk("midrst_mepc", 64'(mepc), 64'(0));
        chk("midrst_mcause", 64'(mcause), 64'(0));
        rst = 1'b0; is_store = 1'b0;

        exp_ret("post_rst", 32'h4, 3'd1);
        run_instr("post_rst",   0,  0,  0,  0, 0,  0,  0, 32'h0,       1, 0, 1);

        repeat (4) @(negedge clk);
        chk("sb_drained", 64'(sb.size()), 64'(0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/cpu_seq.md
Name: cpu_seq

Overview:
- Parametrised multi-cycle instruction sequencer for the RV32 core; replaces the fixed 5-state modulo counter and the in-line PC update.
- Drives the same state encoding: 0 fetch/decode, 1 rf read, 2 execute, 3 mem/gpio, 4 writeback.
- Adds per-stage stall handshakes for fetch, multi-cycle ALU ops (M extension divide) and mmio.
- Adds optional skipping of the mem stage, a bus-timeout trap, a misaligned-target trap and an instruction-retired counter.

Parameters:
- XLEN, 32, width of pc, branch_target and mepc.
- RESET_VECTOR, 32'h0000_0000, pc value after reset.
- TRAP_VECTOR, 32'h0000_0100, pc value loaded on any trap.
- SKIP_MEM, 1, when 1 non-load/store instructions bypass state 3 (EXEC->WB directly); when 0 every instruction spends one cycle in state 3.
- MEM_TIMEOUT, 16, cycles allowed in state 3 waiting for mem_ready before a bus-error trap; 0 disables the timeout.
- CNT_W, 32, width of the instret counter.

Ports:
- CLK100MHZ  in  1  core clock.
- rst  in  1  synchronous active-high reset.
- fetch_ready  in  1  instruction word valid on instr bus this cycle.
- illegal_instr  in  1  decoder found no legal opcode (sampled in state 1).
- exec_busy  in  1  multi-cycle ALU op still running (sampled in state 2).
- is_load  in  1  current instruction is a load.
- is_store  in  1  current instruction is a store.
- mem_ready  in  1  mmio access complete (sampled in state 3).
- taken_branch  in  1  branch/jump taken (sampled in state 4).
- branch_target  in  XLEN  target address from ALU (sampled in state 4).
- state  out  3  current stage, 0..4; 5 = TRAP.
- pc  out  XLEN  program counter.
- wb_en  out  1  register-file write qualifier, high only in a non-trapping state-4 cycle.
- retire  out  1  one-cycle pulse when an instruction completes.
- instret  out  CNT_W  retired-instruction count.
- trap  out  1  one-cycle pulse while in TRAP.
- mepc  out  XLEN  pc of the trapping instruction.
- mcause  out  2  0 misaligned target, 1 illegal instruction, 2 bus timeout.

Behaviour:
- Reset (synchronous, priority over everything, including a reset asserted mid-stall or mid-trap):
  - state=0, pc=RESET_VECTOR, instret=0, mepc=0, mcause=0.
  - wb_en=retire=trap=0; timeout counter cleared.
- All outputs are registered except wb_en, which is decoded combinationally from state and the trap checks.
- State 0 (FETCH): hold while fetch_ready=0; go to 1 on fetch_ready=1. No timeout applies.
- State 1 (RF): always exactly one cycle.
  - illegal_instr=1 -> TRAP with cause 1.
  - Otherwise -> 2.
- State 2 (EXEC): hold while exec_busy=1. When it drops:
  - -> 3 if is_load|is_store, or if SKIP_MEM=0.
  - Otherwise -> 4.
- State 3 (MEM):
  - Non-access instruction (only reachable with SKIP_MEM=0): one cycle, then -> 4.
  - Access: hold until mem_ready=1, then -> 4.
  - Timeout counter clears on entry and increments each waiting cycle.
  - With MEM_TIMEOUT>0, if the counter reaches MEM_TIMEOUT with mem_ready still 0 -> TRAP cause 2.
  - mem_ready=1 in the same cycle the count expires wins: no trap.
- State 4 (WB): always one cycle.
  - Misaligned target (taken_branch=1 and branch_target[1:0]!=0): -> TRAP cause 0; pc unchanged; wb_en=0.
  - Otherwise:
    - pc <= taken_branch ? branch_target : pc+4, wrapping mod 2^XLEN.
    - wb_en=1.
    - retire pulses in the following cycle.
    - instret+1, wrapping to 0 at all-ones.
    - -> 0.
- TRAP (5): one cycle.
  - mepc <= pc, mcause <= latched cause, pc <= TRAP_VECTOR, trap=1.
  - -> 0.
  - No retire, no instret increment.
- Stall inputs are ignored outside their own state.
- is_load/is_store/taken_branch must be held stable by upstream from state 1 through state 4.

Test Plan:
- Reset then ADDI stream, fetch_ready=1, all other stalls 0, SKIP_MEM=1 -> states 0,1,2,4 repeating; pc 0,4,8; retire every 4 cycles; instret=3 after three instructions.
- Store at pc=0x10 with mem_ready delayed 5 cycles -> state 3 held 6 cycles; pc=0x14 after WB; wb_en=1 exactly once.
- Load with mem_ready never asserted, MEM_TIMEOUT=16 -> TRAP after 16 wait cycles; mcause=2; mepc=0x10; pc=0x100; instret unchanged.
- JAL at pc=0x20 with branch_target=0x42 -> TRAP cause 0; mepc=0x20; pc=0x100. Repeat with target 0x40 -> pc=0x40; retire=1.
- illegal_instr=1 in state 1 at pc=0x8; separately exec_busy=1 for 33 cycles -> first case traps with mcause=1, state 2 never entered; second case holds state 2 for 33 cycles with no timeout.
- rst asserted during a state-3 stall with pc=0x30 -> next cycle state=0, pc=0, instret=0; instret seeded at 0xFFFF_FFFF retires once -> 0.
